// File: rtl/mips_dbg_pkg.sv
// Shared types and defaults for the MIPS register-file debug dumper.
package mips_dbg_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 3;
    localparam int FREEZE_CYCLES = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FREEZE = 3'd1,
        ST_READ   = 3'd2,
        ST_SEND   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5
    } dump_state_t;

endpackage

// File: rtl/mips_reg_dumper.sv
// Purpose: freeze the core and stream registers 0..NUM_REGS-1 out on valid/ready (+checksum beat with MIPS_REG_DUMP_CHECKSUM_EN).
// Latency: first out_valid 3 edges after start is sampled; at most one beat per 2 cycles.
// Backpressure: out_* held stable while out_valid && !out_ready; abort cancels at the next edge.
module mips_reg_dumper
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              freeze_req,
    output logic [ADDR_W-1:0] dump_read_reg,
    input  logic [DATA_W-1:0] dump_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              out_is_csum,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_REGS - 1);
    localparam logic [3:0]        SETTLE_LAST = 4'(FREEZE_CYCLES - 1);

    dump_state_t       r_state;
    logic [ADDR_W-1:0] r_index;
    logic [3:0]        r_settle;
    logic              r_freeze;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_index;
    logic              r_out_last;
    logic              r_busy;
    logic              r_done;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;
    logic              r_out_is_csum;
`endif

    logic w_abort;
    logic w_hs;

    assign w_abort = abort && (r_state == ST_FREEZE || r_state == ST_READ ||
                               r_state == ST_SEND   || r_state == ST_CSUM);
    assign w_hs    = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_index     <= '0;
            r_settle    <= '0;
            r_freeze    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
            r_csum        <= '0;
            r_out_is_csum <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                // A beat handshaking on this edge still counts as delivered.
                r_state     <= ST_IDLE;
                r_out_valid <= 1'b0;
                r_freeze    <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state  <= ST_FREEZE;
                            r_freeze <= 1'b1;
                            r_busy   <= 1'b1;
                            r_index  <= '0;
                            r_settle <= '0;
                        end
                    end
                    ST_FREEZE: begin
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
                        r_csum <= '0;
`endif
                        if (r_settle == SETTLE_LAST) begin
                            r_state <= ST_READ;
                        end else begin
                            r_settle <= r_settle + 4'd1;
                        end
                    end
                    ST_READ: begin
                        r_out_data  <= dump_read_data;
                        r_out_index <= r_index;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_SEND;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
                        r_out_last    <= 1'b0;
                        r_out_is_csum <= 1'b0;
                        r_csum        <= r_csum + dump_read_data;
`else
                        r_out_last <= (r_index == LAST_IDX);
`endif
                    end
                    ST_SEND: begin
                        if (w_hs) begin
                            r_out_valid <= 1'b0;
                            if (r_index == LAST_IDX) begin
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
                                r_state <= ST_CSUM;
`else
                                r_state  <= ST_DONE;
                                r_done   <= 1'b1;
                                r_freeze <= 1'b0;
`endif
                            end else begin
                                r_index <= r_index + ADDR_W'(1);
                                r_state <= ST_READ;
                            end
                        end
                    end
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
                    ST_CSUM: begin
                        // First cycle presents the checksum beat, then waits for its handshake.
                        if (!r_out_valid) begin
                            r_out_data    <= r_csum;
                            r_out_index   <= '0;
                            r_out_last    <= 1'b1;
                            r_out_is_csum <= 1'b1;
                            r_out_valid   <= 1'b1;
                        end else if (out_ready) begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_DONE;
                            r_done      <= 1'b1;
                            r_freeze    <= 1'b0;
                        end
                    end
`endif
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign freeze_req    = r_freeze;
    assign dump_read_reg = r_index;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_index     = r_out_index;
    assign out_last      = r_out_last;
    assign busy          = r_busy;
    assign done          = r_done;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
    assign out_is_csum   = r_out_is_csum;
`else
    assign out_is_csum   = 1'b0;
`endif

endmodule
